// File: rtl/phase_bank.sv
// phase_bank: double-buffered multi-channel phase/enable register bank.
// Optional BROADCAST opcode enabled by macro PHASE_BANK_BROADCAST_EN.
module phase_bank #(
  parameter int NUM_CHANNELS = 16,
  parameter int BASE_CHANNEL = 0,
  parameter int PHASE_W      = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cmd_valid,
  input  logic [31:0]                     cmd_data,
  input  logic                            period_start,
  output logic [NUM_CHANNELS*PHASE_W-1:0] phase,
  output logic [NUM_CHANNELS-1:0]         pwm_en,
  output logic                            armed,
  output logic                            commit_done,
  output logic [15:0]                     err_cnt
);

  localparam int PW = PHASE_W;
  localparam int NC = NUM_CHANNELS;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ARMED = 1'b1;

  localparam logic [1:0] OP_WR = 2'b00;
  localparam logic [1:0] OP_BC = 2'b01;
  localparam logic [1:0] OP_CM = 2'b10;
  localparam logic [1:0] OP_WT = 2'b11;

  localparam logic [8:0] LO  = 9'(BASE_CHANNEL);
  localparam logic [8:0] CNT = 9'(NUM_CHANNELS);

  logic [0:0]   state;
  logic [0:0]   state_n;

  logic [NC*PW-1:0] sh_ph;
  logic [NC-1:0]    sh_en;

  logic [1:0]    op;
  logic [7:0]    chan;
  logic [PW-1:0] ph_new;
  logic          en_new;
  logic [8:0]    diff;
  logic          in_range;

  logic is_wr;
  logic is_bc;
  logic is_cm;
  logic is_wt;
  logic bc_ld;
  logic bc_rej;
  logic reject;
  logic apply;

  logic [NC-1:0] hit;
  logic [NC-1:0] sh_ld;
  logic [NC-1:0] act_ld;

  logic unused_bits;

  assign op     = cmd_data[18:17];
  assign chan   = cmd_data[15:8];
  assign en_new = cmd_data[16];
  assign ph_new = cmd_data[PW-1:0];

  assign unused_bits = ^{cmd_data[31:19],
                         cmd_data[7:0]};

  // Below-base channels wrap to >= 256, so one compare covers both ends.
  assign diff     = {1'b0, chan} - LO;
  assign in_range = diff < CNT;

  // Opcode decode, qualified by cmd_valid.
  always_comb begin
    is_wr = 1'b0;
    is_bc = 1'b0;
    is_cm = 1'b0;
    is_wt = 1'b0;
    if (cmd_valid) begin
      unique case (1'b1)
        (op == OP_WR): is_wr = 1'b1;
        (op == OP_BC): is_bc = 1'b1;
        (op == OP_CM): is_cm = 1'b1;
        (op == OP_WT): is_wt = 1'b1;
        default: ;
      endcase
    end
  end

`ifdef PHASE_BANK_BROADCAST_EN
  assign bc_ld  = is_bc;
  assign bc_rej = 1'b0;
`else
  assign bc_ld  = 1'b0;
  assign bc_rej = is_bc;
`endif

  assign reject = ((is_wr | is_wt) & ~in_range)
                | bc_rej;

  assign apply = (state == ST_ARMED)
               & period_start;

  // Per-channel load strobes for shadow and active registers.
  always_comb begin
    hit    = '0;
    sh_ld  = '0;
    act_ld = '0;
    for (int i = 0; i < NC; i++) begin
      hit[i]    = in_range & (diff == 9'(i));
      sh_ld[i]  = ((is_wr | is_wt) & hit[i])
                | bc_ld;
      act_ld[i] = is_wt & hit[i];
    end
  end

  // Two-state commit FSM; a COMMIT while ARMED is ignored.
  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE: begin
        if (is_cm) state_n = ST_ARMED;
      end
      ST_ARMED: begin
        if (period_start) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  assign armed = (state == ST_ARMED);

  // Shadow registers take WRITE, WRITE_THRU and broadcast data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_ph <= '0;
      sh_en <= '0;
    end else begin
      for (int i = 0; i < NC; i++) begin
        if (sh_ld[i]) begin
          sh_ph[i*PW +: PW] <= ph_new;
          sh_en[i]          <= en_new;
        end
      end
    end
  end

  // Active registers: WRITE_THRU wins over the pre-write shadow copy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase  <= '0;
      pwm_en <= '0;
    end else begin
      for (int i = 0; i < NC; i++) begin
        if (act_ld[i]) begin
          phase[i*PW +: PW] <= ph_new;
          pwm_en[i]         <= en_new;
        end else if (apply) begin
          phase[i*PW +: PW] <= sh_ph[i*PW +: PW];
          pwm_en[i]         <= sh_en[i];
        end
      end
    end
  end

  // Pulse marking the cycle the new frame became active.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) commit_done <= 1'b0;
    else     commit_done <= apply;
  end

  // Saturating rejected-command counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (reject && (err_cnt != 16'hFFFF)) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_phase_bank.sv
// tb_phase_bank: scoreboard bench for phase_bank.
// 16 channels, base 16, 8-bit phase.
module tb_phase_bank;

  localparam int NC = 16;
  localparam int PW = 8;

  logic            clk;
  logic            rst;
  logic            cmd_valid;
  logic [31:0]     cmd_data;
  logic            period_start;
  logic [NC*PW-1:0] phase;
  logic [NC-1:0]   pwm_en;
  logic            armed;
  logic            commit_done;
  logic [15:0]     err_cnt;

  phase_bank #(
    .NUM_CHANNELS(NC),
    .BASE_CHANNEL(16),
    .PHASE_W(PW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_data(cmd_data),
    .period_start(period_start),
    .phase(phase),
    .pwm_en(pwm_en),
    .armed(armed),
    .commit_done(commit_done),
    .err_cnt(err_cnt)
  );

  typedef struct {
    logic [NC*PW-1:0] ph;
    logic [NC-1:0]    en;
    logic             arm;
    logic             done;
    logic [15:0]      err;
  } exp_t;

  exp_t q[$];

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] m_sh_ph [NC];
  logic       m_sh_en [NC];
  logic [7:0] m_ph    [NC];
  logic       m_en    [NC];
  logic       m_arm;
  logic       m_done;
  logic [15:0] m_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(string tag,
                       logic [127:0] got,
                       logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [31:0] cmd(
    logic [1:0] op, logic [7:0] ch,
    logic [7:0] p, logic e);
    return {13'd0, op, e, ch, p};
  endfunction

  function automatic exp_t snap();
    exp_t x;
    for (int i = 0; i < NC; i++) begin
      x.ph[i*PW +: PW] = m_ph[i];
      x.en[i]          = m_en[i];
    end
    x.arm  = m_arm;
    x.done = m_done;
    x.err  = m_err;
    return x;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NC; i++) begin
      m_sh_ph[i] = '0;
      m_sh_en[i] = 1'b0;
      m_ph[i]    = '0;
      m_en[i]    = 1'b0;
    end
    m_arm  = 1'b0;
    m_done = 1'b0;
    m_err  = '0;
  endtask

  task automatic m_bump();
    if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
  endtask

  // Reference behaviour for one clock edge.
  task automatic m_step(logic v, logic [31:0] d,
                        logic ps);
    logic [1:0] op;
    int         ch;
    logic       ok;
    logic       app;
    logic       arm_n;
    op    = d[18:17];
    ch    = int'(d[15:8]);
    ok    = (ch >= 16) && (ch < 32);
    app   = m_arm && ps;
    arm_n = app ? 1'b0 : m_arm;
    if (app) begin
      for (int i = 0; i < NC; i++) begin
        m_ph[i] = m_sh_ph[i];
        m_en[i] = m_sh_en[i];
      end
    end
    if (v) begin
      case (op)
        2'b00: begin
          if (ok) begin
            m_sh_ph[ch-16] = d[7:0];
            m_sh_en[ch-16] = d[16];
          end else m_bump();
        end
        2'b01: begin
`ifdef PHASE_BANK_BROADCAST_EN
          for (int i = 0; i < NC; i++) begin
            m_sh_ph[i] = d[7:0];
            m_sh_en[i] = d[16];
          end
`else
          m_bump();
`endif
        end
        2'b10: begin
          if (!m_arm) arm_n = 1'b1;
        end
        default: begin
          if (ok) begin
            m_sh_ph[ch-16] = d[7:0];
            m_sh_en[ch-16] = d[16];
            m_ph[ch-16]    = d[7:0];
            m_en[ch-16]    = d[16];
          end else m_bump();
        end
      endcase
    end
    m_arm  = arm_n;
    m_done = app;
  endtask

  task automatic drive(logic v, logic [31:0] d,
                       logic ps, bit push = 1'b1);
    @(negedge clk);
    cmd_valid    = v;
    cmd_data     = d;
    period_start = ps;
    m_step(v, d, ps);
    if (push) q.push_back(snap());
  endtask

  task automatic idle(logic ps = 1'b0);
    drive(1'b0, 32'hDEAD_BEEF, ps);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Compare each pushed expectation one edge after its stimulus.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("sb_phase", phase, e.ph);
      check("sb_en", pwm_en, e.en);
      check("sb_armed", armed, e.arm);
      check("sb_done", commit_done, e.done);
      check("sb_err", err_cnt, e.err);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: sim time limit hit");
    $fatal(1);
  end

  initial begin
    rst          = 1'b1;
    cmd_valid    = 1'b0;
    cmd_data     = '0;
    period_start = 1'b0;
    m_reset();
    #1;
    check("rst_phase", phase, 128'd0);
    check("rst_en", pwm_en, 128'd0);
    check("rst_armed", armed, 128'd0);
    check("rst_err", err_cnt, 128'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Write without commit: period_start must not apply.
    drive(1'b1, cmd(2'b00, 8'd17, 8'h5A, 1'b1), 1'b0);
    idle(1'b1);
    idle();
    settle();
    check("nocommit_ph1", phase[15:8], 128'd0);
    check("nocommit_en1", pwm_en[1], 128'd0);

    drive(1'b1, cmd(2'b10, 8'd0, 8'd0, 1'b0), 1'b0);
    idle(1'b1);
    settle();
    check("apply_ph1", phase[15:8], 128'h5A);
    check("apply_en1", pwm_en[1], 128'd1);
    check("apply_done", commit_done, 128'd1);
    check("apply_armed", armed, 128'd0);
    idle();

    // Out-of-range channels on both sides of the window.
    drive(1'b1, cmd(2'b00, 8'd15, 8'hAA, 1'b1), 1'b0);
    drive(1'b1, cmd(2'b11, 8'd32, 8'hBB, 1'b1), 1'b0);
    idle();
    settle();
    check("oor_err", err_cnt, 128'd2);
    check("oor_phase", phase, 128'h5A00);

    // COMMIT coinciding with period_start only arms.
    drive(1'b1, cmd(2'b00, 8'd18, 8'h22, 1'b1), 1'b0);
    drive(1'b1, cmd(2'b10, 8'd0, 8'd0, 1'b0), 1'b1);
    idle();
    settle();
    check("cm_ps_armed", armed, 128'd1);
    check("cm_ps_ph2", phase[23:16], 128'd0);
    drive(1'b1, cmd(2'b10, 8'd0, 8'd0, 1'b0), 1'b0);
    idle(1'b1);
    settle();
    check("cm_ps_apply", phase[23:16], 128'h22);

    // WRITE_THRU and WRITE racing an apply.
    drive(1'b1, cmd(2'b00, 8'd16, 8'h11, 1'b1), 1'b0);
    drive(1'b1, cmd(2'b00, 8'd19, 8'h44, 1'b1), 1'b0);
    drive(1'b1, cmd(2'b00, 8'd20, 8'h55, 1'b0), 1'b0);
    drive(1'b1, cmd(2'b10, 8'd0, 8'd0, 1'b0), 1'b0);
    drive(1'b1, cmd(2'b11, 8'd16, 8'h33, 1'b1), 1'b1);
    idle();
    settle();
    check("wt_ph0", phase[7:0], 128'h33);
    check("wt_ph3", phase[31:24], 128'h44);
    check("wt_ph4", phase[39:32], 128'h55);
    drive(1'b1, cmd(2'b00, 8'd20, 8'h66, 1'b1), 1'b0);
    drive(1'b1, cmd(2'b10, 8'd0, 8'd0, 1'b0), 1'b0);
    drive(1'b1, cmd(2'b00, 8'd20, 8'h77, 1'b1), 1'b1);
    idle();
    settle();
    check("wr_race_ph4", phase[39:32], 128'h66);
    drive(1'b1, cmd(2'b10, 8'd0, 8'd0, 1'b0), 1'b0);
    idle(1'b1);
    settle();
    check("sh0_kept", phase[7:0], 128'h33);
    check("wr_race_new", phase[39:32], 128'h77);

    // Async reset while ARMED with loaded shadows.
    drive(1'b1, cmd(2'b00, 8'd21, 8'h99, 1'b1), 1'b0);
    drive(1'b1, cmd(2'b10, 8'd0, 8'd0, 1'b0), 1'b0);
    idle();
    settle();
    check("pre_rst_armed", armed, 128'd1);
    rst = 1'b1;
    m_reset();
    #1;
    check("arst_phase", phase, 128'd0);
    check("arst_en", pwm_en, 128'd0);
    check("arst_armed", armed, 128'd0);
    check("arst_err", err_cnt, 128'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(1'b1);
    idle();
    settle();
    check("post_rst_ph", phase, 128'd0);

    // Broadcast then commit.
    drive(1'b1, cmd(2'b01, 8'd3, 8'h80, 1'b1), 1'b0);
    drive(1'b1, cmd(2'b10, 8'd0, 8'd0, 1'b0), 1'b0);
    idle(1'b1);
    idle();
    settle();
`ifdef PHASE_BANK_BROADCAST_EN
    check("bc_phase", phase, {16{8'h80}});
    check("bc_en", pwm_en, 128'hFFFF);
`else
    check("bc_phase", phase, 128'd0);
    check("bc_err", err_cnt, 128'd1);
`endif

    // Flood of rejected commands saturates the counter.
    for (int i = 0; i < 65540; i++) begin
      drive(1'b1, cmd(2'b00, 8'd0, 8'h01, 1'b1),
            1'b0, 1'b0);
    end
    idle();
    idle();
    settle();
    check("err_sat", err_cnt, 128'hFFFF);

    settle();
    check("sb_drained", q.size(), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
